// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared state encoding and width helper for the LED blink-code sequencer
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// rtl/seq_tick_gen.sv - prescaler producing a one-cycle tick every DIV clocks, restartable by clr
module seq_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_code_sequencer.sv
// rtl/led_code_sequencer.sv - plays N-pulse LED blink codes with an optional repeating trailing gap
module led_code_sequencer
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int ON_T    = 200,
    parameter int OFF_T   = 200,
    parameter int GAP_T   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [3:0] code,
    input  logic       repeat_en,
    input  logic       abort,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       led
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(max3(ON_T, OFF_T, GAP_T) + 1);

    localparam logic [PW-1:0] ON_LAST  = PW'(ON_T - 1);
    localparam logic [PW-1:0] OFF_LAST = PW'(OFF_T - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'(GAP_T - 1);

    seq_state_e    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    pulse_q, pulse_d;
    logic [3:0]    code_q, code_d;
    logic          led_q, led_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          clr;
    logic          tick;
    logic [PW-1:0] phase_last;

    seq_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        case (state_q)
            ST_ON:   phase_last = ON_LAST;
            ST_OFF:  phase_last = OFF_LAST;
            ST_GAP:  phase_last = GAP_LAST;
            default: phase_last = '0;
        endcase
    end

    // clr restarts the prescaler on every phase entry so each phase is exactly T*DIV clocks
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pulse_d = pulse_q;
        code_d  = code_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        clr     = 1'b0;

        if (state_q == ST_IDLE) begin
            clr = 1'b1;
            if (req && !abort) begin
                ack_d = 1'b1;
                if (code != 4'd0) begin
                    code_d  = code;
                    pulse_d = 4'd1;
                    phase_d = '0;
                    state_d = ST_ON;
                end
            end
        end else if (abort) begin
            clr     = 1'b1;
            phase_d = '0;
            pulse_d = 4'd0;
            state_d = ST_IDLE;
        end else if (tick) begin
            if (phase_q == phase_last) begin
                clr     = 1'b1;
                phase_d = '0;
                case (state_q)
                    ST_ON: begin
                        state_d = (pulse_q < code_q) ? ST_OFF : ST_GAP;
                    end
                    ST_OFF: begin
                        pulse_d = pulse_q + 4'd1;
                        state_d = ST_ON;
                    end
                    ST_GAP: begin
                        if (repeat_en) begin
                            pulse_d = 4'd1;
                            state_d = ST_ON;
                        end else begin
                            pulse_d = 4'd0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            pulse_q <= 4'd0;
            code_q  <= 4'd0;
            led_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pulse_q <= pulse_d;
            code_q  <= code_d;
            led_q   <= led_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign led  = led_q;
    assign ack  = ack_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_code_sequencer.sv
// tb/tb_led_code_sequencer.sv - self-checking bench comparing the LED waveform against a pattern model
module tb_led_code_sequencer;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int ON_T    = 2;
    localparam int OFF_T   = 3;
    localparam int GAP_T   = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [3:0] code = 4'd0;
    logic       repeat_en = 1'b0;
    logic       abort = 1'b0;
    logic       ack;
    logic       busy;
    logic       done;
    logic       led;

    int checks = 0;
    int failures = 0;

    led_code_sequencer #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .ON_T   (ON_T),
        .OFF_T  (OFF_T),
        .GAP_T  (GAP_T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .code     (code),
        .repeat_en(repeat_en),
        .abort    (abort),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .led      (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_led"}, led, 0);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_done"}, done, 0);
            chk({tag, "_ack"}, ack, 0);
            @(negedge clk);
        end
    endtask

    // Expected LED level for every cycle after the accept edge, built pulse by pulse.
    task automatic play(input string tag, input logic [3:0] c, input int plays, input bit keep_req);
        bit pat[$];
        int total;
        int drop_at;
        pat = {};
        for (int p = 0; p < plays; p++) begin
            for (int n = 1; n <= c; n++) begin
                repeat (ON_T * DIV) pat.push_back(1'b1);
                if (n < c) repeat (OFF_T * DIV) pat.push_back(1'b0);
                else       repeat (GAP_T * DIV) pat.push_back(1'b0);
            end
        end
        total   = pat.size();
        drop_at = (plays > 1) ? total - (GAP_T * DIV) / 2 : -1;
        repeat_en = (plays > 1);
        req  = 1'b1;
        code = c;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < total; k++) begin
            chk({tag, "_led"}, led, int'(pat[k]));
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_done"}, done, 0);
            chk({tag, "_ack"}, ack, (k == 0) ? 1 : 0);
            if (k == 0 && !keep_req) req = 1'b0;
            if (k == drop_at) repeat_en = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_end_done"}, done, 1);
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_led"}, led, 0);
        chk({tag, "_end_ack"}, ack, 0);
    endtask

    initial begin
        logic [3:0] rc;

        #12;
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk("post_rst", 3);

        play("code3", 4'd3, 1, 1'b0);
        @(negedge clk);
        idle_chk("after_code3", 3);

        for (int i = 0; i < 4; i++) begin
            rc = 4'($urandom_range(1, 15));
            play("rand", rc, 1, 1'b0);
            @(negedge clk);
            idle_chk("rand_idle", 2);
        end

        play("repeat1", 4'd1, 3, 1'b0);
        @(negedge clk);
        idle_chk("after_rep1", 2);

        rc = 4'($urandom_range(2, 6));
        play("repeat_rand", rc, 2, 1'b0);
        @(negedge clk);
        idle_chk("after_rep_rand", 2);

        play("b2b_first", 4'd2, 1, 1'b1);
        play("b2b_second", 4'd2, 1, 1'b0);
        @(negedge clk);
        idle_chk("after_b2b", 2);

        req  = 1'b1;
        code = 4'd0;
        @(negedge clk);
        chk("code0_ack", ack, 1);
        chk("code0_led", led, 0);
        chk("code0_busy", busy, 0);
        chk("code0_done", done, 0);
        req = 1'b0;
        @(negedge clk);
        idle_chk("code0_idle", 20);

        req   = 1'b1;
        code  = 4'd5;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_idle_ack", ack, 0);
        chk("abort_idle_busy", busy, 0);
        req   = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        req  = 1'b1;
        code = 4'd4;
        @(negedge clk);
        chk("abort_seq_ack", ack, 1);
        chk("abort_seq_led", led, 1);
        req = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle_chk("abort_after", GAP_T * DIV + 10);
        play("post_abort", 4'd2, 1, 1'b0);
        @(negedge clk);

        req  = 1'b1;
        code = 4'd5;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        chk("prersn_led", led, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", led, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ack", ack, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk("arst_idle", 30);
        rc = 4'($urandom_range(1, 15));
        play("post_arst", rc, 1, 1'b0);
        @(negedge clk);
        idle_chk("final_idle", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
